// File: rtl/vldst_unit.sv
// ---------------------------------------------------------------------------
// vldst_unit -- vector load/store engine for a 16 x 16-bit vector.
//
// A vld (Op=0) reads 16 consecutive memory words starting at BaseAddr into
// VecOut. A vst (Op=1) writes the 16 elements of VecIn to 16 consecutive
// memory words starting at BaseAddr. Addresses wrap modulo 2^16.
//
// Memory model assumed: the memory samples Addr/RD on a rising edge and the
// read data on DataIn is valid for capture on the following rising edge.
//
// Ports
//   Clk1      in   1    sole clock, rising edge
//   Reset     in   1    asynchronous, active-low reset
//   Start     in   1    request pulse, sampled only in IDLE
//   Op        in   1    0 = vld (memory->vector), 1 = vst (vector->memory)
//   BaseAddr  in   16   word address of element 0, sampled with Start
//   VecIn     in   256  vector to store, element i = VecIn[16i+15:16i]
//   VecOut    out  256  last loaded vector, same packing
//   Busy      out  1    high in every state except IDLE
//   Done      out  1    one-cycle completion pulse
//   Addr      out  16   memory word address
//   RD        out  1    memory read strobe
//   WR        out  1    memory write strobe
//   DataOut   out  16   memory write data
//   DataIn    in   16   memory read data
// ---------------------------------------------------------------------------
module vldst_unit (
  input  logic         Clk1,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Op,
  input  logic [15:0]  BaseAddr,
  input  logic [255:0] VecIn,
  output logic [255:0] VecOut,
  output logic         Busy,
  output logic         Done,
  output logic [15:0]  Addr,
  output logic         RD,
  output logic         WR,
  output logic [15:0]  DataOut,
  input  logic [15:0]  DataIn
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LDRAIN = 3'd2,
    ST_STORE  = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  // Pick element idx out of a packed 16 x 16-bit vector.
  function automatic logic [15:0] elem_sel(input logic [255:0] vec,
                                           input logic [3:0]   idx);
    return vec[{idx, 4'b0000} +: 16];
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     k_q, k_d;
  logic [15:0]    base_q, base_d;
  logic [255:0]   vec_in_q, vec_in_d;
  logic [255:0]   shadow_q, shadow_d;
  logic [255:0]   vec_out_q, vec_out_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    data_out_q, data_out_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [3:0]     k_inc_s;
  logic [3:0]     cap_idx_s;

  assign k_inc_s   = k_q + 4'd1;
  // Read data lags the presented address by one element: while address k is
  // on the bus, DataIn carries element k-1.
  assign cap_idx_s = k_q - 4'd1;

  // Next-state and next-output logic for the load/store sequencer.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    base_d     = base_q;
    vec_in_d   = vec_in_q;
    shadow_d   = shadow_q;
    vec_out_d  = vec_out_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          base_d   = BaseAddr;
          vec_in_d = VecIn;
          k_d      = 4'd0;
          addr_d   = BaseAddr;
          if (Op) begin
            state_d    = ST_STORE;
            wr_d       = 1'b1;
            data_out_d = elem_sel(VecIn, 4'd0);
          end else begin
            state_d = ST_LOAD;
            rd_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (k_q != 4'd0) begin
          shadow_d[{cap_idx_s, 4'b0000} +: 16] = DataIn;
        end else begin
          shadow_d = shadow_q;
        end
        if (k_q == 4'd15) begin
          state_d = ST_LDRAIN;
          k_d     = 4'd0;
        end else begin
          k_d    = k_inc_s;
          addr_d = base_q + {12'd0, k_inc_s};
          rd_d   = 1'b1;
        end
      end

      ST_LDRAIN: begin
        // Last element arrives now; publish the whole vector in one edge.
        shadow_d[255:240] = DataIn;
        vec_out_d         = {DataIn, shadow_q[239:0]};
        done_d            = 1'b1;
        state_d           = ST_FIN;
      end

      ST_STORE: begin
        if (k_q == 4'd15) begin
          state_d = ST_FIN;
          k_d     = 4'd0;
          done_d  = 1'b1;
        end else begin
          k_d        = k_inc_s;
          addr_d     = base_q + {12'd0, k_inc_s};
          data_out_d = elem_sel(vec_in_q, k_inc_s);
          wr_d       = 1'b1;
        end
      end

      ST_FIN: begin
        // Start is deliberately not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        k_d     = 4'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops with asynchronous active-low reset.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      k_q        <= 4'd0;
      base_q     <= 16'd0;
      vec_in_q   <= 256'd0;
      shadow_q   <= 256'd0;
      vec_out_q  <= 256'd0;
      addr_q     <= 16'd0;
      data_out_q <= 16'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      vec_in_q   <= vec_in_d;
      shadow_q   <= shadow_d;
      vec_out_q  <= vec_out_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign VecOut  = vec_out_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Addr    = addr_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign DataOut = data_out_q;

endmodule

// File: doc/vldst_unit.md
VLDST_UNIT -- requirements
Module: vldst_unit

Interface
REQ-001 SHALL have port Clk1  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  in  1  asynchronous, active-low; Reset=0 forces reset state immediately, independent of Clk1.
REQ-003 SHALL have port Start  in  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port Op  in  1  0=vld (memory->vector), 1=vst (vector->memory); sampled with Start.
REQ-005 SHALL have port BaseAddr  in  16  word address of element 0; sampled with Start.
REQ-006 SHALL have port VecIn  in  256  vector to store; element i = VecIn[16i+15:16i]; sampled with Start.
REQ-007 SHALL have port VecOut  out  256  loaded vector, same element packing.
REQ-008 SHALL have port Busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port Done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port Addr  out  16  memory word address.
REQ-011 SHALL have port RD  out  1  memory read strobe.
REQ-012 SHALL have port WR  out  1  memory write strobe.
REQ-013 SHALL have port DataOut  out  16  memory write data.
REQ-014 SHALL have port DataIn  in  16  memory read data.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, LDRAIN, STORE, FIN; all outputs registered.
REQ-016 SHALL leave IDLE on edge E0 when Start=1: Op=0 -> LOAD, Op=1 -> STORE; capture Op, BaseAddr, VecIn into internal registers at E0.
REQ-017 SHALL ignore Start while Busy=1; Op/BaseAddr/VecIn changes while Busy have no effect.
REQ-018 SHALL use 4-bit element counter k, 0..15; Addr = BaseAddr + k modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-019 Memory timing SHALL be: memory samples Addr/RD at edge En, DataIn valid for capture at edge En+1.
REQ-020 LOAD SHALL drive RD=1, Addr=BaseAddr+k in the cycles after E0..E15 (k=0..15); after E16 RD=0, state LDRAIN.
REQ-021 Element k SHALL be captured from DataIn at edge E(k+2) into a shadow register; element 15 captured at E17.
REQ-022 VecOut SHALL update atomically from the shadow at E17, same edge Done goes high; VecOut SHALL otherwise hold its value (including through vst operations).
REQ-023 STORE SHALL drive WR=1, Addr=BaseAddr+k, DataOut=element k in the cycles after E0..E15; after E16 WR=0, Done=1, state FIN.
REQ-024 Done SHALL be high for exactly one cycle (state FIN); next edge returns to IDLE, Busy=0; a Start present at that edge is ignored, accepted from the following edge.
REQ-025 RD and WR SHALL never be high in the same cycle; RD=WR=0 in IDLE, LDRAIN, FIN.
REQ-026 Addr and DataOut SHALL hold last driven value when strobes are low (don't-care to memory).
REQ-027 Total latency: vld Done in cycle after E17 (18 edges from Start); vst Done in cycle after E16 (17 edges).

Reset
REQ-028 Reset=0 SHALL force state IDLE, k=0, VecOut=0, shadow=0, Addr=0, DataOut=0, RD=0, WR=0, Busy=0, Done=0.
REQ-029 Reset asserted mid-operation SHALL abort it: strobes drop immediately, no Done, VecOut=0; first Start after Reset rises is accepted normally.

Verification
REQ-030 vld: memory[0x0100+i]=0x1000+i, Start,Op=0,BaseAddr=0x0100 -> RD high 16 cycles on 0x0100..0x010F, Done at cycle 18, VecOut[15:0]=0x1000, VecOut[255:240]=0x100F.
REQ-031 vst: VecIn elements=0xA000+i, BaseAddr=0x0200 -> WR high 16 cycles, DataOut 0xA000..0xA00F on 0x0200..0x020F, Done at cycle 17, VecOut unchanged.
REQ-032 wrap: vld BaseAddr=0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007, elements in order.
REQ-033 Start held high continuously through a vst -> exactly one operation per IDLE entry; Start at Done cycle ignored, next operation begins one edge later.
REQ-034 Reset=0 asynchronously at cycle 8 of vld -> RD=0, Busy=0, VecOut=0 before next Clk1 edge; no Done pulse.
REQ-035 VecIn/BaseAddr changed at cycle 3 of vst -> written data and addresses match values sampled at E0.
